hbm_fc_wt_fetch_sched: RTL

//  Sequences HBM weight+scale fetches for one FC/MVM+BN layer. Walks CHout tiles x CHin scale groups and issues
//  one scale read then one weight read per group to the HBM read engine. Tracks outstanding reads, signals layer done.

---
 rtl/hbm_fc_wt_fetch_sched.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/hbm_fc_wt_fetch_sched.sv
`default_nettype none
// ============================================================================
// Module   : hbm_fc_wt_fetch_sched
// Purpose  : Issues scale-then-weight HBM reads per scale group across all
//            CHout tiles of an FC/MVM+BN layer; tracks outstanding reads.
// Revision : 1.0  initial release
// ============================================================================
module hbm_fc_wt_fetch_sched #(
  parameter int ADDR_W          = 32,
  parameter int CNT_W           = 16,
  parameter int BYTES_W         = 20,
  parameter int SCALE_BYTES     = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [ADDR_W-1:0]  cfg_wt_base_addr_i,
  input  logic [CNT_W-1:0]   cfg_chout_tiles_i,
  input  logic [CNT_W-1:0]   cfg_groups_i,
  input  logic [BYTES_W-1:0] cfg_group_bytes_i,
  input  logic [BYTES_W-1:0] cfg_last_group_bytes_i,
  output logic               req_valid_o,
  input  logic               req_ready_i,
  output logic [ADDR_W-1:0]  req_addr_o,
  output logic [BYTES_W-1:0] req_bytes_o,
  output logic               req_is_scale_o,
  output logic [CNT_W-1:0]   req_tile_o,
  output logic [CNT_W-1:0]   req_group_o,
  output logic               req_last_o,
  input  logic               rsp_done_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_cfg_o
);

  localparam int                 OUT_W         = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0]   C_MAX_OUT     = OUT_W'(MAX_OUTSTANDING);
  localparam logic [OUT_W-1:0]   C_OUT_ONE     = OUT_W'(1);
  localparam logic [CNT_W-1:0]   C_CNT_ONE     = CNT_W'(1);
  localparam logic [BYTES_W-1:0] C_SCALE_BYTES = BYTES_W'(SCALE_BYTES);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CHECK     = 3'd1,
    S_ISS_SCALE = 3'd2,
    S_ISS_WT    = 3'd3,
    S_DRAIN     = 3'd4,
    S_DONE      = 3'd5,
    S_ERR_DONE  = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   tiles_q, groups_q;
  logic [BYTES_W-1:0] gbytes_q, lbytes_q;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]   tile_q, tile_d;
  logic [CNT_W-1:0]   group_q, group_d;
  logic [OUT_W-1:0]   outst_q, outst_d;
  logic               err_q, err_d;

  logic               w_start_acc;
  logic               w_issue;
  logic               w_hs;
  logic               w_rsp;
  logic               w_last_grp;
  logic               w_last_tile;
  logic [BYTES_W-1:0] w_wt_bytes;
  logic [BYTES_W-1:0] w_req_bytes;

  assign w_start_acc = (state_q == S_IDLE) && start_i;
  assign w_issue     = (state_q == S_ISS_SCALE) || (state_q == S_ISS_WT);
  assign req_valid_o = w_issue && (outst_q < C_MAX_OUT);
  assign w_hs        = req_valid_o && req_ready_i;
  assign w_rsp       = rsp_done_i && (outst_q != '0);
  assign w_last_grp  = (group_q == groups_q - C_CNT_ONE);
  assign w_last_tile = (tile_q == tiles_q - C_CNT_ONE);
  // A zero last-group size means the last group is a full-size group.
  assign w_wt_bytes  = (w_last_grp && (lbytes_q != '0)) ? lbytes_q : gbytes_q;
  assign w_req_bytes = (state_q == S_ISS_SCALE) ? C_SCALE_BYTES : w_wt_bytes;

  assign req_addr_o     = w_issue ? ptr_q : '0;
  assign req_bytes_o    = w_issue ? w_req_bytes : '0;
  assign req_is_scale_o = (state_q == S_ISS_SCALE);
  assign req_tile_o     = w_issue ? tile_q : '0;
  assign req_group_o    = w_issue ? group_q : '0;
  assign req_last_o     = (state_q == S_ISS_WT) && w_last_grp && w_last_tile;
  assign busy_o         = (state_q != S_IDLE);
  assign done_o         = (state_q == S_DONE) || (state_q == S_ERR_DONE);
  assign err_cfg_o      = err_q;

  always_comb begin
    outst_d = outst_q;
    if (w_hs && !w_rsp) begin
      outst_d = outst_q + C_OUT_ONE;
    end else if (!w_hs && w_rsp) begin
      outst_d = outst_q - C_OUT_ONE;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    tile_d  = tile_q;
    group_d = group_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          ptr_d   = cfg_wt_base_addr_i;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if ((tiles_q == '0) || (groups_q == '0) || (gbytes_q == '0)) begin
          err_d   = 1'b1;
          state_d = S_ERR_DONE;
        end else begin
          err_d   = 1'b0;
          tile_d  = '0;
          group_d = '0;
          state_d = S_ISS_SCALE;
        end
      end
      S_ISS_SCALE: begin
        if (w_hs) begin
          ptr_d   = ptr_q + ADDR_W'(C_SCALE_BYTES);
          state_d = S_ISS_WT;
        end
      end
      S_ISS_WT: begin
        if (w_hs) begin
          ptr_d = ptr_q + ADDR_W'(w_wt_bytes);
          if (w_last_grp) begin
            group_d = '0;
            if (w_last_tile) begin
              state_d = S_DRAIN;
            end else begin
              tile_d  = tile_q + C_CNT_ONE;
              state_d = S_ISS_SCALE;
            end
          end else begin
            group_d = group_q + C_CNT_ONE;
            state_d = S_ISS_SCALE;
          end
        end
      end
      // Look at the next-cycle count so done follows the final response directly.
      S_DRAIN: begin
        if (outst_d == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE:     state_d = S_IDLE;
      S_ERR_DONE: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      tiles_q  <= '0;
      groups_q <= '0;
      gbytes_q <= '0;
      lbytes_q <= '0;
      ptr_q    <= '0;
      tile_q   <= '0;
      group_q  <= '0;
      outst_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      tile_q  <= tile_d;
      group_q <= group_d;
      outst_q <= outst_d;
      err_q   <= err_d;
      if (w_start_acc) begin
        tiles_q  <= cfg_chout_tiles_i;
        groups_q <= cfg_groups_i;
        gbytes_q <= cfg_group_bytes_i;
        lbytes_q <= cfg_last_group_bytes_i;
      end
    end
  end

endmodule
`default_nettype wire
